// File: rtl/aes_key_expand_pkg.sv
// Shared AES-128 definitions: S-box, GF(2^8) doubling, key-schedule constants
// and the key-expansion FSM encoding.
package aes_key_expand_pkg;

  localparam int NR = 10;
  localparam int IDX_W = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Entry 0 is listed first, so SBOX[x] is the substitution of byte x.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_sub_word.sv
// 32-bit SubWord: four independent S-box lookups, shared table with SubBytes.
module aes_sub_word
  import aes_key_expand_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] result
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign result[8*gi +: 8] = sbox(word[8*gi +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// register store, read combinationally by round index.
module aes_key_expand
  import aes_key_expand_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst,
  input  logic [127:0]     iKey,
  input  logic             iStart,
  input  logic [IDX_W-1:0] iRoundIdx,
  output logic [127:0]     oRoundKey,
  output logic             oBusy,
  output logic             oKeyValid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] cnt_reg;
  logic [7:0]       rcon_reg;
  logic [127:0]     rk_reg [0:NR];

  logic         load;
  logic         step;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  sub_rot;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;

  // A start is honoured from IDLE or DONE only; mid-expansion requests are dropped.
  assign load = (state_reg != EXPAND) && iStart;
  assign step = (state_reg == EXPAND);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (iStart) state_next = EXPAND;
      EXPAND:     if (cnt_reg == LAST_IDX) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rcon_reg  <= RCON_INIT;
    end else begin
      state_reg <= state_next;
      if (load) begin
        cnt_reg  <= IDX_W'(1);
        rcon_reg <= RCON_INIT;
      end else if (step) begin
        cnt_reg  <= cnt_reg + IDX_W'(1);
        rcon_reg <= xtime(rcon_reg);
      end
    end
  end

  // Previous round key feeding the round function is rk[cnt-1].
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NR; i++) begin
      if (cnt_reg == IDX_W'(i + 1)) prev_key = rk_reg[i];
    end
  end

  aes_sub_word u_sub_word (
    .word   ({prev_key[23:0], prev_key[31:24]}),
    .result (sub_rot)
  );

  assign t_word   = sub_rot ^ {rcon_reg, 24'h0};
  assign n0       = prev_key[127:96] ^ t_word;
  assign n1       = prev_key[95:64] ^ n0;
  assign n2       = prev_key[63:32] ^ n1;
  assign n3       = prev_key[31:0] ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i <= NR; i++) rk_reg[i] <= '0;
    end else if (load) begin
      rk_reg[0] <= iKey;
    end else if (step) begin
      for (int i = 1; i <= NR; i++) begin
        if (cnt_reg == IDX_W'(i)) rk_reg[i] <= next_key;
      end
    end
  end

  // Indices beyond the last round read as zero.
  always_comb begin
    oRoundKey = '0;
    for (int i = 0; i <= NR; i++) begin
      if (iRoundIdx == IDX_W'(i)) oRoundKey = rk_reg[i];
    end
  end

  assign oBusy     = (state_reg == EXPAND);
  assign oKeyValid = (state_reg == DONE);

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against an independent key-schedule model.
module tb_aes_key_expand;

  logic         iClk;
  logic         iRst;
  logic [127:0] iKey;
  logic         iStart;
  logic [3:0]   iRoundIdx;
  logic [127:0] oRoundKey;
  logic         oBusy;
  logic         oKeyValid;

  int vectors;
  int miscompares;

  logic [7:0]   model_sbox [0:255];
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iKey      (iKey),
    .iStart    (iStart),
    .iRoundIdx (iRoundIdx),
    .oRoundKey (oRoundKey),
    .oBusy     (oBusy),
    .oKeyValid (oKeyValid)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference model: S-box derived from GF(2^8) inverse plus affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      repeat (254) inv = gf_mul(inv, 8'(x));
      model_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word-oriented expansion over w[0..43].
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {model_sbox[temp[31:24]], model_sbox[temp[23:16]],
                model_sbox[temp[15:8]], model_sbox[temp[7:0]]};
        temp = temp ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic pulse_start(input logic [127:0] key);
    @(negedge iClk);
    iKey = key;
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iKey = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts cycles (from the negedge after the start edge) until oKeyValid; -1 on timeout.
  task automatic wait_valid(output int cycles, output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (!oKeyValid && n < 30) begin
      if (oBusy) busy_cycles++;
      @(negedge iClk);
      n++;
    end
    cycles = oKeyValid ? n : -1;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    vectors++;
    if (oBusy !== 1'b0 || oKeyValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags busy=%b valid=%b required busy=0 valid=0", oBusy, oKeyValid);
    end
    for (int i = 0; i < 16; i++) begin
      iRoundIdx = i[3:0];
      #1;
      vectors++;
      if (oRoundKey !== 128'h0) begin
        miscompares++;
        $display("FAIL reset_key idx=%0d got=%h required=0", i, oRoundKey);
      end
    end
    $display("reset: flags and 16 indices checked");
  endtask

  task automatic test_fips();
    int cycles, busy;
    pulse_start(FIPS_KEY);
    wait_valid(cycles, busy);
    vectors++;
    if (cycles !== 10) begin
      miscompares++;
      $display("FAIL fips_latency got=%0d required=10 (cycles after start edge)", cycles);
    end
    vectors++;
    if (busy !== 10) begin
      miscompares++;
      $display("FAIL fips_busy got=%0d required=10", busy);
    end
    iRoundIdx = 4'd0; #1; vectors++;
    if (oRoundKey !== FIPS_KEY) begin
      miscompares++; $display("FAIL fips_idx0 got=%h required=%h", oRoundKey, FIPS_KEY);
    end
    iRoundIdx = 4'd1; #1; vectors++;
    if (oRoundKey !== FIPS_RK1) begin
      miscompares++; $display("FAIL fips_idx1 got=%h required=%h", oRoundKey, FIPS_RK1);
    end
    iRoundIdx = 4'd10; #1; vectors++;
    if (oRoundKey !== FIPS_RK10) begin
      miscompares++; $display("FAIL fips_idx10 got=%h required=%h", oRoundKey, FIPS_RK10);
    end
    $display("fips: latency=%0d busy=%0d idx10=%h", cycles, busy, oRoundKey);
  endtask

  task automatic test_zero_key();
    int cycles, busy;
    pulse_start(128'h0);
    wait_valid(cycles, busy);
    vectors++;
    if (cycles !== 10) begin
      miscompares++; $display("FAIL zero_latency got=%0d required=10", cycles);
    end
    iRoundIdx = 4'd1; #1; vectors++;
    if (oRoundKey !== ZERO_RK1) begin
      miscompares++; $display("FAIL zero_idx1 got=%h required=%h", oRoundKey, ZERO_RK1);
    end
    iRoundIdx = 4'd10; #1; vectors++;
    if (oRoundKey !== ZERO_RK10) begin
      miscompares++; $display("FAIL zero_idx10 got=%h required=%h", oRoundKey, ZERO_RK10);
    end
    for (int i = 11; i < 16; i++) begin
      iRoundIdx = i[3:0]; #1; vectors++;
      if (oRoundKey !== 128'h0) begin
        miscompares++; $display("FAIL zero_oob idx=%0d got=%h required=0", i, oRoundKey);
      end
    end
    $display("zero key: idx1/idx10/out-of-range checked");
  endtask

  task automatic test_mid_expand_start();
    int n = 0;
    pulse_start(FIPS_KEY);
    while (!oKeyValid && n < 30) begin
      iStart = (n == 3);
      iKey = (n == 3) ? 128'h00112233445566778899aabbccddeeff : iKey;
      @(negedge iClk);
      n++;
    end
    iStart = 1'b0;
    vectors++;
    if (n !== 10 || !oKeyValid) begin
      miscompares++; $display("FAIL mid_start_latency got=%0d required=10", n);
    end
    model_expand(FIPS_KEY);
    for (int i = 0; i <= 10; i++) begin
      iRoundIdx = i[3:0]; #1; vectors++;
      if (oRoundKey !== exp_rk[i]) begin
        miscompares++; $display("FAIL mid_start_key idx=%0d got=%h required=%h", i, oRoundKey, exp_rk[i]);
      end
    end
    $display("mid-expand start: ignored, latency=%0d", n);
  endtask

  task automatic test_restart_from_done();
    int cycles, busy;
    vectors++;
    if (oKeyValid !== 1'b1) begin
      miscompares++; $display("FAIL restart_precond valid=%b required=1", oKeyValid);
    end
    pulse_start(128'h0);
    vectors++;
    if (oKeyValid !== 1'b0 || oBusy !== 1'b1) begin
      miscompares++; $display("FAIL restart_drop valid=%b busy=%b required valid=0 busy=1", oKeyValid, oBusy);
    end
    wait_valid(cycles, busy);
    vectors++;
    if (cycles !== 10) begin
      miscompares++; $display("FAIL restart_latency got=%0d required=10", cycles);
    end
    iRoundIdx = 4'd10; #1; vectors++;
    if (oRoundKey !== ZERO_RK10) begin
      miscompares++; $display("FAIL restart_idx10 got=%h required=%h", oRoundKey, ZERO_RK10);
    end
    $display("restart from done: latency=%0d idx10=%h", cycles, oRoundKey);
  endtask

  task automatic test_reset_mid_expand();
    int cycles, busy;
    logic [127:0] key;
    pulse_start(FIPS_KEY);
    repeat (4) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    vectors++;
    if (oBusy !== 1'b0 || oKeyValid !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_flags busy=%b valid=%b required 0/0", oBusy, oKeyValid);
    end
    for (int i = 0; i < 16; i++) begin
      iRoundIdx = i[3:0]; #1; vectors++;
      if (oRoundKey !== 128'h0) begin
        miscompares++; $display("FAIL rst_mid_clear idx=%0d got=%h required=0", i, oRoundKey);
      end
    end
    key = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key);
    pulse_start(key);
    wait_valid(cycles, busy);
    vectors++;
    if (cycles !== 10) begin
      miscompares++; $display("FAIL rst_mid_relatency got=%0d required=10", cycles);
    end
    for (int i = 0; i <= 10; i++) begin
      iRoundIdx = i[3:0]; #1; vectors++;
      if (oRoundKey !== exp_rk[i]) begin
        miscompares++; $display("FAIL rst_mid_rekey idx=%0d got=%h required=%h", i, oRoundKey, exp_rk[i]);
      end
    end
    $display("reset mid-expand: cleared, rerun key=%h", key);
  endtask

  task automatic test_reset_vs_start();
    @(negedge iClk);
    iRst = 1'b1;
    iStart = 1'b1;
    iKey = FIPS_KEY;
    @(negedge iClk);
    iRst = 1'b0;
    iStart = 1'b0;
    vectors++;
    if (oBusy !== 1'b0 || oKeyValid !== 1'b0) begin
      miscompares++; $display("FAIL rst_start_flags busy=%b valid=%b required 0/0", oBusy, oKeyValid);
    end
    @(negedge iClk);
    vectors++;
    if (oBusy !== 1'b0 || oKeyValid !== 1'b0) begin
      miscompares++; $display("FAIL rst_start_idle busy=%b valid=%b required 0/0", oBusy, oKeyValid);
    end
    iRoundIdx = 4'd0; #1; vectors++;
    if (oRoundKey !== 128'h0) begin
      miscompares++; $display("FAIL rst_start_idx0 got=%h required=0", oRoundKey);
    end
    $display("reset with start: reset wins, busy=%b", oBusy);
  endtask

  task automatic test_random_keys();
    int cycles, busy;
    logic [127:0] key;
    for (int t = 0; t < 6; t++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      pulse_start(key);
      wait_valid(cycles, busy);
      vectors++;
      if (cycles !== 10 || busy !== 10) begin
        miscompares++; $display("FAIL rand_timing key=%h latency=%0d busy=%0d required 10/10", key, cycles, busy);
      end
      for (int i = 0; i < 16; i++) begin
        iRoundIdx = i[3:0]; #1; vectors++;
        if (oRoundKey !== ((i <= 10) ? exp_rk[i] : 128'h0)) begin
          miscompares++;
          $display("FAIL rand_key key=%h idx=%0d got=%h required=%h", key, i, oRoundKey,
                   (i <= 10) ? exp_rk[i] : 128'h0);
        end
      end
      $display("random key %0d: %h idx10=%h", t, key, exp_rk[10]);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    iRst = 1'b1;
    iStart = 1'b0;
    iKey = '0;
    iRoundIdx = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_mid_expand_start();
    test_restart_from_done();
    test_reset_mid_expand();
    test_reset_vs_start();
    test_random_keys();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
